// File: rtl/uart_rx_word_assembler.sv
// uart_rx_word_assembler
//   Packs bytes from a UART receiver into 32-bit words for a CPU-side register.
//   Bytes are taken through the receiver's level flag / single-cycle clear
//   handshake. Four bytes make a full word. A partial word is flushed after
//   TIMEOUT_CYCLES idle clocks; 0 disables the timeout. The finished word sits
//   in an output holding register with a valid/ack handshake. A sticky overrun
//   flag records bytes that arrive while the assembler is stalled on the
//   output register.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous, active-high reset
//   rx_data_i      received byte
//   rx_flag_i      receiver byte-ready level
//   rx_flag_clr_o  one-cycle clear pulse back to the receiver
//   word_o         assembled word; unused lanes are zero
//   byte_cnt_o     number of valid bytes in word_o (1..4)
//   word_valid_o   word_o / byte_cnt_o / timeout_o are valid
//   word_ack_i     consumer accepts the presented word
//   timeout_o      presented word was flushed by the timeout
//   overrun_o      sticky back-pressure error
//   overrun_clr_i  clears overrun_o
module uart_rx_word_assembler #(
    parameter int TIMEOUT_CYCLES = 57310,
    parameter bit LSB_FIRST      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_flag_i,
    output logic        rx_flag_clr_o,
    output logic [31:0] word_o,
    output logic [2:0]  byte_cnt_o,
    output logic        word_valid_o,
    input  logic        word_ack_i,
    output logic        timeout_o,
    output logic        overrun_o,
    input  logic        overrun_clr_i
);

    // The counter only has to reach TIMEOUT_CYCLES-1.
    localparam int               CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_CLR   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      asm_q, asm_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [31:0]      word_q, word_d;
    logic [2:0]       byte_cnt_q, byte_cnt_d;
    logic             timeout_q, timeout_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    logic             out_free;
    logic             partial;
    logic             xfer;
    logic             xfer_timeout;
    logic [1:0]       lane;

    assign out_free = !valid_q || word_ack_i;
    assign partial  = (idx_q != 3'd0) && (idx_q < 3'd4);
    // MSB-first packing fills from the top lane down, so partial words stay left-aligned.
    assign lane     = LSB_FIRST ? idx_q[1:0] : (2'd3 - idx_q[1:0]);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        asm_d        = asm_q;
        tcnt_d       = tcnt_q;
        xfer         = 1'b0;
        xfer_timeout = 1'b0;

        case (state_q)
            ST_WAIT: begin
                // A flag still high here is a new byte: the previous one was
                // cleared at the end of the CLR cycle.
                if (rx_flag_i) begin
                    asm_d[{lane, 3'b000} +: 8] = rx_data_i;
                    idx_d   = idx_q + 3'd1;
                    tcnt_d  = '0;
                    state_d = ST_CLR;
                end else if (TIMEOUT_EN && partial && (tcnt_q == CNT_LAST)) begin
                    // Flush request; when the output is busy the counter stays
                    // saturated so the request repeats every cycle.
                    if (out_free) begin
                        xfer         = 1'b1;
                        xfer_timeout = 1'b1;
                    end
                end else if (partial) begin
                    if (tcnt_q != CNT_LAST) begin
                        tcnt_d = tcnt_q + CNT_W'(1);
                    end
                end
            end
            ST_CLR: begin
                if (idx_q == 3'd4) begin
                    if (out_free) begin
                        xfer    = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_STALL;
                    end
                end else begin
                    state_d = ST_WAIT;
                    if (partial && (tcnt_q != CNT_LAST)) begin
                        tcnt_d = tcnt_q + CNT_W'(1);
                    end
                end
            end
            ST_STALL: begin
                if (out_free) begin
                    xfer    = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase

        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        timeout_d  = timeout_q;
        valid_d    = valid_q;
        if (xfer) begin
            // Ack and transfer in one cycle simply replace the word: no bubble.
            word_d     = asm_q;
            byte_cnt_d = idx_q;
            timeout_d  = xfer_timeout;
            valid_d    = 1'b1;
            idx_d      = 3'd0;
            asm_d      = 32'd0;
            tcnt_d     = '0;
        end else if (word_ack_i) begin
            valid_d = 1'b0;
        end

        // Set wins over clear.
        overrun_d = overrun_q;
        if ((state_q == ST_STALL) && rx_flag_i) begin
            overrun_d = 1'b1;
        end else if (overrun_clr_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_WAIT;
            idx_q      <= 3'd0;
            asm_q      <= 32'd0;
            tcnt_q     <= '0;
            word_q     <= 32'd0;
            byte_cnt_q <= 3'd0;
            timeout_q  <= 1'b0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            asm_q      <= asm_d;
            tcnt_q     <= tcnt_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            timeout_q  <= timeout_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    // Decoded from the registered state, so the pulse is glitch-free and lasts exactly one cycle.
    assign rx_flag_clr_o = (state_q == ST_CLR);
    assign word_o        = word_q;
    assign byte_cnt_o    = byte_cnt_q;
    assign word_valid_o  = valid_q;
    assign timeout_o     = timeout_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Bench for uart_rx_word_assembler. Two instances share all inputs: one packs
// LSB-first, the other MSB-first, both with a 100-cycle timeout.
module tb_uart_rx_word_assembler;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_flag;
    logic        word_ack;
    logic        overrun_clr;

    logic        clr_a, valid_a, to_a, ovr_a;
    logic [31:0] word_a;
    logic [2:0]  cnt_a;
    logic        clr_b, valid_b, to_b, ovr_b;
    logic [31:0] word_b;
    logic [2:0]  cnt_b;

    uart_rx_word_assembler #(.TIMEOUT_CYCLES(TO), .LSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .rx_data_i(rx_data), .rx_flag_i(rx_flag),
        .rx_flag_clr_o(clr_a), .word_o(word_a), .byte_cnt_o(cnt_a),
        .word_valid_o(valid_a), .word_ack_i(word_ack), .timeout_o(to_a),
        .overrun_o(ovr_a), .overrun_clr_i(overrun_clr)
    );

    uart_rx_word_assembler #(.TIMEOUT_CYCLES(TO), .LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .rx_data_i(rx_data), .rx_flag_i(rx_flag),
        .rx_flag_clr_o(clr_b), .word_o(word_b), .byte_cnt_o(cnt_b),
        .word_valid_o(valid_b), .word_ack_i(word_ack), .timeout_o(to_b),
        .overrun_o(ovr_b), .overrun_clr_i(overrun_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lsb;
        logic [31:0] msb;
        logic [2:0]  cnt;
        logic        to;
    } exp_t;

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        int          n;
        logic [31:0] lsb;
        logic [31:0] msb;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[6];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkvec(input logic [7:0] b0, input logic [7:0] b1,
                                   input logic [7:0] b2, input logic [7:0] b3,
                                   input int n, input logic [31:0] lsb, input logic [31:0] msb);
        vec_t v;
        v.b0 = b0; v.b1 = b1; v.b2 = b2; v.b3 = b3;
        v.n = n; v.lsb = lsb; v.msb = msb;
        return v;
    endfunction

    function automatic logic [7:0] pick(input vec_t v, input int i);
        case (i)
            0:       return v.b0;
            1:       return v.b1;
            2:       return v.b2;
            default: return v.b3;
        endcase
    endfunction

    task automatic push_exp(input logic [31:0] lsb, input logic [31:0] msb,
                            input logic [2:0] cnt, input logic to);
        exp_t e;
        e.lsb = lsb; e.msb = msb; e.cnt = cnt; e.to = to;
        exp_q.push_back(e);
    endtask

    // Called just after a rising edge. Acts as the receiver: raise the flag,
    // drop it at the edge that ends the clear-pulse cycle.
    task automatic send_byte(input logic [7:0] b);
        int k;
        rx_data = b;
        rx_flag = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!clr_a && k < 50);
        check("clr_latency", 64'(k), 64'd2);
        @(posedge clk); #1;
        rx_flag = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        if (exp_q.size() != 0) exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic check_outs_zero(input string name);
        check({name, "_a"}, 64'({word_a, cnt_a, valid_a, to_a, ovr_a, clr_a}), 64'd0);
        check({name, "_b"}, 64'({word_b, cnt_b, valid_b, to_b, ovr_b, clr_b}), 64'd0);
    endtask

    // Scoreboard: a new word is presented when valid rises or stays high
    // right after an accepted word.
    initial begin : monitor
        logic pv, pa, pc;
        exp_t e;
        pv = 1'b0; pa = 1'b0; pc = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0; pa = 1'b0; pc = 1'b0;
            end else begin
                if (clr_a) check("clr_one_cycle", 64'(pc), 64'd0);
                if (valid_a && (!pv || pa)) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_word: got %0h with no word queued", word_a);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_lsb", 64'(word_a), 64'(e.lsb));
                        check("cnt_lsb", 64'(cnt_a), 64'(e.cnt));
                        check("timeout_lsb", 64'(to_a), 64'(e.to));
                        check("valid_msb", 64'(valid_b), 64'd1);
                        check("word_msb", 64'(word_b), 64'(e.msb));
                        check("cnt_msb", 64'(cnt_b), 64'(e.cnt));
                        check("timeout_msb", 64'(to_b), 64'(e.to));
                    end
                end
                pv = valid_a; pa = word_ack; pc = clr_a;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k;
        tbl[0] = mkvec(8'hC0, 8'hFF, 8'hEE, 8'h00, 4, 32'h00EEFFC0, 32'hC0FFEE00);
        tbl[1] = mkvec(8'hAB, 8'h00, 8'h00, 8'h00, 1, 32'h000000AB, 32'hAB000000);
        tbl[2] = mkvec(8'h12, 8'h34, 8'h56, 8'h78, 4, 32'h78563412, 32'h12345678);
        tbl[3] = mkvec(8'hDE, 8'hAD, 8'hBE, 8'h00, 3, 32'h00BEADDE, 32'hDEADBE00);
        tbl[4] = mkvec(8'hFF, 8'h00, 8'h80, 8'h01, 4, 32'h018000FF, 32'hFF008001);
        tbl[5] = mkvec(8'h5A, 8'h0F, 8'h00, 8'h00, 2, 32'h00000F5A, 32'h5A0F0000);

        rst = 1'b1; rx_data = 8'h00; rx_flag = 1'b0; word_ack = 1'b0; overrun_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs_zero("reset_state");
        @(posedge clk); #1;
        rst = 1'b0;

        // Table vectors with ack held high; partial vectors end in a timeout flush.
        word_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_exp(tbl[i].lsb, tbl[i].msb, 3'(tbl[i].n), (tbl[i].n < 4));
            for (int j = 0; j < tbl[i].n; j++) send_byte(pick(tbl[i], j));
            wait_drain("table_drain");
        end

        // Full word latency and one-cycle valid with ack held.
        push_exp(32'h44332211, 32'h11223344, 3'd4, 1'b0);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        @(negedge clk);
        check("valid_two_after_flag", 64'(valid_a), 64'd1);
        @(negedge clk);
        check("valid_one_cycle", 64'(valid_a), 64'd0);
        wait_drain("latency_drain");

        // Timeout latency: valid TO+1 cycles after the last capture cycle.
        push_exp(32'h00005AA5, 32'hA55A0000, 3'd2, 1'b1);
        send_byte(8'hA5); send_byte(8'h5A);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!valid_a && k < 300);
        check("timeout_latency", 64'(k), 64'(TO));
        wait_drain("timeout_drain");

        // Back-pressure: second word stalls, ninth byte raises overrun.
        word_ack = 1'b0;
        push_exp(32'h44332211, 32'h11223344, 3'd4, 1'b0);
        push_exp(32'hDDCCBBAA, 32'hAABBCCDD, 3'd4, 1'b0);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        rx_data = 8'h99;
        rx_flag = 1'b1;
        @(negedge clk);
        check("overrun_not_yet", 64'(ovr_a), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_no_clr", 64'(clr_a), 64'd0);
            check("overrun_set", 64'(ovr_a), 64'd1);
        end
        @(posedge clk); #1;
        overrun_clr = 1'b1;
        @(posedge clk); #1;
        overrun_clr = 1'b0;
        @(negedge clk);
        check("overrun_set_wins", 64'(ovr_a), 64'd1);
        check("first_word_held", 64'(word_a), 64'h44332211);
        @(posedge clk); #1;
        word_ack = 1'b1;
        @(posedge clk); #1;
        word_ack = 1'b0;
        @(negedge clk);
        check("stalled_word_out", 64'(word_a), 64'hDDCCBBAA);
        check("stalled_word_valid", 64'(valid_a), 64'd1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!clr_a && k < 10);
        check("pending_byte_consumed", 64'(k), 64'd1);
        @(posedge clk); #1;
        rx_flag = 1'b0;
        push_exp(32'h00000099, 32'h99000000, 3'd1, 1'b1);
        repeat (150) @(negedge clk);
        check("flush_held_valid", 64'(valid_a), 64'd1);
        check("flush_held_word", 64'(word_a), 64'hDDCCBBAA);
        @(posedge clk); #1;
        overrun_clr = 1'b1;
        @(posedge clk); #1;
        overrun_clr = 1'b0;
        @(negedge clk);
        check("overrun_cleared", 64'(ovr_a), 64'd0);
        @(posedge clk); #1;
        word_ack = 1'b1;
        wait_drain("stall_drain");

        // Ack in the same cycle as the CLR-cycle completion: no bubble.
        word_ack = 1'b0;
        push_exp(32'h40302010, 32'h10203040, 3'd4, 1'b0);
        push_exp(32'h80706050, 32'h50607080, 3'd4, 1'b0);
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
        send_byte(8'h50); send_byte(8'h60); send_byte(8'h70);
        rx_data = 8'h80;
        rx_flag = 1'b1;
        @(posedge clk); #1;
        word_ack = 1'b1;
        @(negedge clk);
        check("same_cycle_clr", 64'(clr_a), 64'd1);
        check("same_cycle_old_word", 64'(word_a), 64'h40302010);
        @(posedge clk); #1;
        word_ack = 1'b0;
        rx_flag = 1'b0;
        @(negedge clk);
        check("no_bubble_valid", 64'(valid_a), 64'd1);
        check("no_bubble_word", 64'(word_a), 64'h80706050);
        @(posedge clk); #1;
        word_ack = 1'b1;
        wait_drain("same_cycle_drain");

        // Asynchronous reset mid-word and while a word is presented.
        send_byte(8'hEE); send_byte(8'hEF);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_outs_zero("reset_mid_word");
        @(posedge clk); #1;
        rst = 1'b0;
        word_ack = 1'b0;
        push_exp(32'h34333231, 32'h31323334, 3'd4, 1'b0);
        send_byte(8'h31); send_byte(8'h32); send_byte(8'h33); send_byte(8'h34);
        @(negedge clk);
        check("pre_reset_valid", 64'(valid_a), 64'd1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_outs_zero("reset_while_valid");
        @(posedge clk); #1;
        rst = 1'b0;
        word_ack = 1'b1;
        push_exp(32'h04030201, 32'h01020304, 3'd4, 1'b0);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        wait_drain("post_reset_drain");

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
